// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan controller: active-low hex glyphs and segment layout.
package seg7_pkg;

    localparam int unsigned SEG_W  = 7;
    localparam int unsigned DISP_W = 8;
    localparam int unsigned DP_BIT = 7;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

    // Active-low {g,f,e,d,c,b,a} for hex digits 0..F
    localparam logic [SEG_W-1:0] SEG_HEX [0:15] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble to active-low 7-segment glyph lookup.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0]       nibble,
    output logic [SEG_W-1:0] seg_c
);

    assign seg_c = SEG_HEX[nibble];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scan controller: priority channel latch with hold, digit scan with
// leading-zero blanking, per-digit DP and an all-off blank window at the start of every slot.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter  int unsigned NUM_DIGITS  = 8,
    parameter  int unsigned NUM_CH      = 3,
    parameter  int unsigned REFRESH_DIV = 50000,
    parameter  int unsigned BLANK_CYC   = 16,
    parameter  int unsigned DEFAULT_CH  = 2,
    localparam int unsigned CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [NUM_CH*32-1:0]   ch_data,
    input  logic [NUM_CH-1:0]      ch_valid,
    input  logic                   hold,
    input  logic                   lz_blank,
    input  logic [NUM_DIGITS-1:0]  dp_mask,
    output logic [DISP_W-1:0]      tubeDisplay,
    output logic [NUM_DIGITS-1:0]  tubeSelect,
    output logic [31:0]            shown_data,
    output logic [CH_W-1:0]        shown_ch
);

    localparam int unsigned DIG_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned PRESC_W = $clog2(REFRESH_DIV);

    logic [PRESC_W-1:0]    presc;
    logic [DIG_W-1:0]      dig;
    logic                  presc_wrap_c;
    logic                  slot_blank_c;
    logic [31:0]           sel_data_c;
    logic [CH_W-1:0]       sel_ch_c;
    logic [3:0]            nibble_c;
    logic [SEG_W-1:0]      hex_seg_c;
    logic                  upper_nz_c;
    logic [NUM_DIGITS-1:0] lz_mask_c;
    logic [DISP_W-1:0]     display_c;
    logic [NUM_DIGITS-1:0] select_c;

    assign presc_wrap_c = (presc == PRESC_W'(REFRESH_DIV - 1));
    assign slot_blank_c = (presc < PRESC_W'(BLANK_CYC));

    // Slot prescaler and digit counter
    always_ff @(posedge CLK) begin
        if (RST) begin
            presc <= '0;
            dig   <= '0;
        end else if (presc_wrap_c) begin
            presc <= '0;
            dig   <= (dig == DIG_W'(NUM_DIGITS - 1)) ? '0 : dig + DIG_W'(1);
        end else begin
            presc <= presc + PRESC_W'(1);
        end
    end

    // Lowest-index valid channel wins; fall back to the default channel
    always_comb begin
        sel_ch_c   = CH_W'(DEFAULT_CH);
        sel_data_c = ch_data[32*DEFAULT_CH +: 32];
        for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
            if (ch_valid[i]) begin
                sel_ch_c   = CH_W'(i);
                sel_data_c = ch_data[32*i +: 32];
            end
        end
    end

    // Digit k blanks when it and every more-significant nibble are zero
    always_comb begin
        lz_mask_c  = '0;
        upper_nz_c = 1'b0;
        for (int k = int'(NUM_DIGITS) - 1; k >= 1; k--) begin
            upper_nz_c   = upper_nz_c | (|shown_data[4*k +: 4]);
            lz_mask_c[k] = lz_blank & ~upper_nz_c;
        end
    end

    always_comb begin
        nibble_c = '0;
        for (int k = 0; k < int'(NUM_DIGITS); k++) begin
            if (dig == DIG_W'(k)) begin
                nibble_c = shown_data[4*k +: 4];
            end
        end
    end

    seg7_hex_decode u_hex_decode (
        .nibble (nibble_c),
        .seg_c  (hex_seg_c)
    );

    always_comb begin
        select_c  = '1;
        display_c = '1;
        if (!slot_blank_c) begin
            select_c[dig]     = 1'b0;
            display_c[SEG_W-1:0] = lz_mask_c[dig] ? SEG_BLANK : hex_seg_c;
            display_c[DP_BIT] = ~dp_mask[dig];
        end
    end

    // Latched value and registered tube drive
    always_ff @(posedge CLK) begin
        if (RST) begin
            shown_data  <= '0;
            shown_ch    <= CH_W'(DEFAULT_CH);
            tubeDisplay <= '1;
            tubeSelect  <= '1;
        end else begin
            tubeDisplay <= display_c;
            tubeSelect  <= select_c;
            if (!hold) begin
                shown_data <= sel_data_c;
                shown_ch   <= sel_ch_c;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: table-driven scans, hand sequences for reset/hold, randomized model check.
module tb_seg7_scan_ctrl;

    localparam int R   = 4;
    localparam int B   = 1;
    localparam int N   = 8;
    localparam int C   = 3;
    localparam int DEF = 2;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [95:0] ch_data = '0;
    logic [2:0]  ch_valid = '0;
    logic        hold = 1'b0;
    logic        lz_blank = 1'b0;
    logic [7:0]  dp_mask = '0;
    logic [7:0]  tubeDisplay;
    logic [7:0]  tubeSelect;
    logic [31:0] shown_data;
    logic [1:0]  shown_ch;

    always #5 CLK = ~CLK;

    seg7_scan_ctrl #(
        .NUM_DIGITS (N),
        .NUM_CH     (C),
        .REFRESH_DIV(R),
        .BLANK_CYC  (B),
        .DEFAULT_CH (DEF)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .ch_data    (ch_data),
        .ch_valid   (ch_valid),
        .hold       (hold),
        .lz_blank   (lz_blank),
        .dp_mask    (dp_mask),
        .tubeDisplay(tubeDisplay),
        .tubeSelect (tubeSelect),
        .shown_data (shown_data),
        .shown_ch   (shown_ch)
    );

    int n_run  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    logic [7:0] hex8 [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                              8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    // Expected segment byte for digit d of value data
    function automatic logic [7:0] exp_disp(input logic [31:0] data, input int d,
                                            input logic lz, input logic [7:0] dpm);
        logic [31:0] upper;
        logic [7:0]  code;
        int          nib;
        upper = data >> (4*d);
        nib   = int'(upper & 32'hF);
        code  = hex8[nib];
        if (lz && d != 0 && upper == 32'h0) code = 8'hFF;
        code[7] = ~dpm[d];
        return code;
    endfunction

    // Reference model: cycle count since reset gives slot position directly
    int          m_n  = 0;
    logic        m_ok = 1'b0;
    logic [31:0] m_data;
    logic [1:0]  m_ch;
    logic [7:0]  m_disp;
    logic [7:0]  m_sel;

    always @(posedge CLK) begin
        int  p, d;
        bit  found;
        if (RST) begin
            m_n = 0; m_ok = 1'b1;
            m_data = 32'h0; m_ch = 2'(DEF);
            m_disp = 8'hFF; m_sel = 8'hFF;
        end else if (m_ok) begin
            p = m_n % R;
            d = (m_n / R) % N;
            if (p < B) begin
                m_disp = 8'hFF; m_sel = 8'hFF;
            end else begin
                m_sel  = ~(8'd1 << d);
                m_disp = exp_disp(m_data, d, lz_blank, dp_mask);
            end
            if (!hold) begin
                found = 1'b0;
                for (int i = 0; i < C; i++) begin
                    if (!found && ch_valid[i]) begin
                        found = 1'b1;
                        m_ch = 2'(i);
                        m_data = ch_data[32*i +: 32];
                    end
                end
                if (!found) begin
                    m_ch = 2'(DEF);
                    m_data = ch_data[32*DEF +: 32];
                end
            end
            m_n = (m_n + 1) % (R*N);
        end
    end

    always @(negedge CLK) begin
        if (m_ok) begin
            check("model_display", 64'(tubeDisplay), 64'(m_disp));
            check("model_select",  64'(tubeSelect),  64'(m_sel));
            check("model_data",    64'(shown_data),  64'(m_data));
            check("model_ch",      64'(shown_ch),    64'(m_ch));
        end
    end

    typedef struct packed {
        logic [2:0]  valid;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [31:0] d2;
        logic        lz;
        logic [7:0]  dp;
        logic [1:0]  exp_ch;
        logic [31:0] exp_data;
        logic [63:0] exp_dig;   // {digit7 .. digit0}
    } vec_t;

    vec_t vecs [8];

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    initial begin
        logic [63:0] got;
        int          blanks, bad_sel;

        vecs[0] = '{3'b000, 32'h0, 32'h0, 32'h0040_1000, 1'b0, 8'h00, 2'd2, 32'h0040_1000, 64'hC0C099C0F9C0C0C0};
        vecs[1] = '{3'b011, 32'h1234_5678, 32'hDEAD_BEEF, 32'h0, 1'b0, 8'h00, 2'd0, 32'h1234_5678, 64'hF9A4B0999282F880};
        vecs[2] = '{3'b001, 32'h0000_00A5, 32'h0, 32'h0, 1'b1, 8'h00, 2'd0, 32'h0000_00A5, 64'hFFFFFFFFFFFF8892};
        vecs[3] = '{3'b001, 32'h0, 32'h5, 32'h6, 1'b1, 8'h00, 2'd0, 32'h0, 64'hFFFFFFFFFFFFFFC0};
        vecs[4] = '{3'b001, 32'h0, 32'h5, 32'h6, 1'b1, 8'h01, 2'd0, 32'h0, 64'hFFFFFFFFFFFFFF40};
        vecs[5] = '{3'b110, 32'h1111_1111, 32'h89AB_CDEF, 32'h2222_2222, 1'b0, 8'hF0, 2'd1, 32'h89AB_CDEF, 64'h00100803C6A1868E};
        vecs[6] = '{3'b001, 32'h0000_0100, 32'h0, 32'h0, 1'b1, 8'h80, 2'd0, 32'h0000_0100, 64'h7FFFFFFFFFF9C0C0};
        vecs[7] = '{3'b000, 32'h0000_0ABC, 32'h7, 32'hFEDC_0000, 1'b1, 8'h00, 2'd2, 32'hFEDC_0000, 64'h8E86A1C6C0C0C0C0};

        // Reset state, then first scan of the default channel
        ch_data = {32'h0040_1000, 32'h0, 32'h0};
        RST = 1'b1;
        tick(3);
        check("reset_display", 64'(tubeDisplay), 64'hFF);
        check("reset_select",  64'(tubeSelect),  64'hFF);
        check("reset_data",    64'(shown_data),  64'h0);
        check("reset_ch",      64'(shown_ch),    64'd2);
        RST = 1'b0;
        tick(1);
        check("t1_blank_select", 64'(tubeSelect), 64'hFF);
        check("t1_ch",           64'(shown_ch),   64'd2);
        check("t1_data",         64'(shown_data), 64'h0040_1000);
        tick(12);
        check("t1_dig3_blank", 64'(tubeSelect), 64'hFF);
        tick(1);
        check("t1_dig3_select",  64'(tubeSelect),  64'hF7);
        check("t1_dig3_display", 64'(tubeDisplay), 64'hF9);

        // Table-driven full scans
        for (int v = 0; v < 8; v++) begin
            ch_valid = vecs[v].valid;
            ch_data  = {vecs[v].d2, vecs[v].d1, vecs[v].d0};
            lz_blank = vecs[v].lz;
            dp_mask  = vecs[v].dp;
            hold     = 1'b0;
            tick(2);
            got = 'x; blanks = 0; bad_sel = 0;
            for (int c = 0; c < R*N; c++) begin
                if (tubeSelect == 8'hFF) begin
                    blanks++;
                end else begin
                    if ($countones(~tubeSelect) != 1) bad_sel++;
                    for (int k = 0; k < N; k++)
                        if (!tubeSelect[k]) got[8*k +: 8] = tubeDisplay;
                end
                tick(1);
            end
            check($sformatf("vec%0d_ch", v),   64'(shown_ch),   64'(vecs[v].exp_ch));
            check($sformatf("vec%0d_data", v), 64'(shown_data), 64'(vecs[v].exp_data));
            check($sformatf("vec%0d_blanks", v), 64'(blanks), 64'(N*B));
            check($sformatf("vec%0d_onehot", v), 64'(bad_sel), 64'd0);
            for (int k = 0; k < N; k++)
                check($sformatf("vec%0d_digit%0d", v, k), 64'(got[8*k +: 8]), 64'(vecs[v].exp_dig[8*k +: 8]));
        end

        // Hold freezes value and channel across a full scan
        lz_blank = 1'b0; dp_mask = 8'h00;
        ch_valid = 3'b001;
        ch_data  = {32'h0, 32'h0, 32'hCAFE_F00D};
        tick(2);
        check("hold_pre_data", 64'(shown_data), 64'hCAFE_F00D);
        hold     = 1'b1;
        ch_valid = 3'b010;
        ch_data  = {32'h5555_6666, 32'h3333_4444, 32'h1111_2222};
        for (int c = 0; c < R*N + 2; c++) begin
            tick(1);
            check("hold_data", 64'(shown_data), 64'hCAFE_F00D);
            check("hold_ch",   64'(shown_ch),   64'd0);
        end
        hold = 1'b0;
        tick(1);
        check("unhold_data", 64'(shown_data), 64'h3333_4444);
        check("unhold_ch",   64'(shown_ch),   64'd1);

        // Reset mid-slot at dig=5, presc=2
        RST = 1'b1;
        tick(1);
        RST = 1'b0;
        tick(22);
        check("mid_pre_select", 64'(tubeSelect), 64'hDF);
        RST = 1'b1;
        tick(1);
        check("mid_rst_display", 64'(tubeDisplay), 64'hFF);
        check("mid_rst_select",  64'(tubeSelect),  64'hFF);
        check("mid_rst_data",    64'(shown_data),  64'h0);
        check("mid_rst_ch",      64'(shown_ch),    64'd2);
        RST = 1'b0;
        tick(1);
        check("mid_restart_blank", 64'(tubeSelect), 64'hFF);
        tick(1);
        check("mid_restart_dig0", 64'(tubeSelect), 64'hFE);

        // Randomized stimulus against the model
        for (int c = 0; c < 400; c++) begin
            ch_valid = 3'($urandom_range(0, 7));
            ch_data  = {$urandom() >> $urandom_range(0, 31),
                        $urandom() >> $urandom_range(0, 31),
                        $urandom() >> $urandom_range(0, 31)};
            hold     = ($urandom_range(0, 3) == 0);
            lz_blank = 1'($urandom_range(0, 1));
            dp_mask  = 8'($urandom());
            tick(1);
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
